axi_ni_request_splitter: RTL



---
 rtl/axi_ni_request_splitter_if.sv | 60 ++++++
 rtl/axi_ni_request_splitter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ni_request_splitter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_ni_request_splitter_if
// Brief    : AXI read/write address channels plus the encoded packet-request
//            channel between the NI request splitter and the packetizer.
//            The slave modport is the splitter's view, master the initiator's.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_ni_request_splitter_if #(
    parameter int AXIADDRWD = 32,
    parameter int AXIDATAWD = 32,
    parameter int AXILENWD  = 8,
    parameter int PKTLENWD  = 9
);
    // AXI read address channel
    logic                   arvalid;
    logic                   arready;
    logic [AXIADDRWD-1:0]   araddr;
    logic [AXILENWD-1:0]    arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;

    // AXI write address channel
    logic                   awvalid;
    logic                   awready;
    logic [AXIADDRWD-1:0]   awaddr;
    logic [AXILENWD-1:0]    awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;

    // Encoded packet request towards the packetizer
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic                   pkt_write;
    logic [AXIADDRWD-1:0]   pkt_address;
    logic [PKTLENWD-1:0]    pkt_burst_length;
    logic [2:0]             pkt_burst_increment;
    logic [1:0]             pkt_burst_sequence;
    logic [AXIDATAWD/8-1:0] pkt_byte_enables;
    logic                   pkt_last;

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  pkt_ready,
        output arready, awready,
        output pkt_valid, pkt_write, pkt_address, pkt_burst_length,
        output pkt_burst_increment, pkt_burst_sequence, pkt_byte_enables, pkt_last
    );

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        output awvalid, awaddr, awlen, awsize, awburst,
        output pkt_ready,
        input  arready, awready,
        input  pkt_valid, pkt_write, pkt_address, pkt_burst_length,
        input  pkt_burst_increment, pkt_burst_sequence, pkt_byte_enables, pkt_last
    );
endinterface
`default_nettype wire

// File: rtl/axi_ni_request_splitter.sv
`default_nettype none
// ============================================================================
// Module   : axi_ni_request_splitter
// Brief    : Registered AXI address-request splitter for the initiator NI.
//            Round-robin arbitration between AR and AW, INCR bursts longer
//            than MAX_PKT_BURST split into several packet requests, encoded
//            header fields presented through a valid/ready output register.
//            Optional macro NI_SPLIT_STATS_EN adds saturating request/split
//            counters (stat_reads, stat_writes, stat_splits).
// Revision : 1.0 - initial release
// ============================================================================
module axi_ni_request_splitter #(
    parameter int AXIADDRWD     = 32,
    parameter int AXIDATAWD     = 32,
    parameter int AXILENWD      = 8,
    parameter int MAX_PKT_BURST = 16,
    parameter int PKTLENWD      = 9
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    axi_ni_request_splitter_if.slave bus
`ifdef NI_SPLIT_STATS_EN
    ,
    output logic [15:0]              stat_reads,
    output logic [15:0]              stat_writes,
    output logic [15:0]              stat_splits
`endif
);

    localparam int                  c_be_wd     = AXIDATAWD / 8;
    localparam int                  c_off_wd    = $clog2(c_be_wd);
    localparam logic [PKTLENWD-1:0] c_max_beats = PKTLENWD'(MAX_PKT_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_prefer_write;
    logic [AXIADDRWD-1:0]   r_addr;
    logic [PKTLENWD-1:0]    r_remaining;
    logic [2:0]             r_size;
    logic [1:0]             r_burst;
    logic                   r_write;

    logic                   r_pkt_valid;
    logic                   r_pkt_write;
    logic [AXIADDRWD-1:0]   r_pkt_address;
    logic [PKTLENWD-1:0]    r_pkt_len;
    logic [2:0]             r_pkt_incr;
    logic [1:0]             r_pkt_seq;
    logic [c_be_wd-1:0]     r_pkt_ben;
    logic                   r_pkt_last;

    logic                   w_out_free;
    logic                   w_accept_ok;
    logic                   w_grant_read;
    logic                   w_grant_write;
    logic                   w_ar_take;
    logic                   w_aw_take;
    logic                   w_accept;
    logic                   w_split_step;
    logic                   w_load;

    logic                   w_src_write;
    logic [AXIADDRWD-1:0]   w_src_addr;
    logic [PKTLENWD-1:0]    w_src_remaining;
    logic [2:0]             w_src_size;
    logic [1:0]             w_src_burst;

    logic                   w_split_ok;
    logic [PKTLENWD-1:0]    w_beats;
    logic [PKTLENWD-1:0]    w_rem_after;
    logic [AXIADDRWD-1:0]   w_next_addr;
    logic [AXIADDRWD-1:0]   w_chunk_addr;
    logic [1:0]             w_seq;
    logic [c_be_wd-1:0]     w_ben;

    // Read byte enables: 2^size contiguous lanes from the address offset,
    // clipped at the top lane; sizes wider than the bus cover the whole bus.
    function automatic logic [c_be_wd-1:0] f_read_ben(
        input logic [c_off_wd-1:0] off,
        input logic [2:0]          size
    );
        int                 n;
        logic [c_be_wd-1:0] be;
        n  = (int'(size) > c_off_wd) ? c_be_wd : (1 << size);
        be = '0;
        for (int i = 0; i < c_be_wd; i++) begin
            be[i] = (i >= int'(off)) && (i < int'(off) + n);
        end
        return be;
    endfunction

    // Arbitration: a new request is taken only in IDLE with the output
    // register free or draining; on contention the channel not served last wins.
    assign w_out_free    = !r_pkt_valid || bus.pkt_ready;
    assign w_accept_ok   = (r_state == ST_IDLE) && w_out_free;
    assign w_grant_read  = bus.arvalid && (!bus.awvalid || !r_prefer_write);
    assign w_grant_write = bus.awvalid && (!bus.arvalid ||  r_prefer_write);
    assign w_ar_take     = w_accept_ok && w_grant_read;
    assign w_aw_take     = w_accept_ok && w_grant_write;
    assign w_accept      = w_ar_take || w_aw_take;
    assign w_split_step  = (r_state == ST_SPLIT) && bus.pkt_ready;
    assign w_load        = w_accept || w_split_step;

    assign bus.arready   = w_ar_take;
    assign bus.awready   = w_aw_take;

    // Chunk source: the incoming AXI request in IDLE, the stored remainder in SPLIT.
    always_comb begin
        w_src_write     = r_write;
        w_src_addr      = r_addr;
        w_src_remaining = r_remaining;
        w_src_size      = r_size;
        w_src_burst     = r_burst;
        if (r_state == ST_IDLE) begin
            w_src_write = w_grant_write;
            if (w_grant_write) begin
                w_src_addr      = bus.awaddr;
                w_src_remaining = PKTLENWD'(bus.awlen) + PKTLENWD'(1);
                w_src_size      = bus.awsize;
                w_src_burst     = bus.awburst;
            end else begin
                w_src_addr      = bus.araddr;
                w_src_remaining = PKTLENWD'(bus.arlen) + PKTLENWD'(1);
                w_src_size      = bus.arsize;
                w_src_burst     = bus.arburst;
            end
        end
    end

    // burst[0] set means INCR (01) or reserved (11): both are treated as INCR
    // and may be split; FIXED (00) and WRAP (10) always go out as one chunk.
    assign w_split_ok   = w_src_burst[0];
    assign w_seq        = w_src_burst[0] ? 2'b01 : w_src_burst;
    assign w_beats      = (w_split_ok && (w_src_remaining > c_max_beats)) ? c_max_beats
                                                                           : w_src_remaining;
    assign w_rem_after  = w_src_remaining - w_beats;
    assign w_next_addr  = w_src_addr + (AXIADDRWD'(w_beats) << w_src_size);
    assign w_chunk_addr = w_src_addr & ~((AXIADDRWD'(1) << w_src_size) - AXIADDRWD'(1));
    assign w_ben        = w_src_write ? {c_be_wd{1'b1}}
                                      : f_read_ben(w_src_addr[c_off_wd-1:0], w_src_size);

    // Control FSM with the registered packet-request outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_prefer_write <= 1'b0;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_size         <= '0;
            r_burst        <= '0;
            r_write        <= 1'b0;
            r_pkt_valid    <= 1'b0;
            r_pkt_write    <= 1'b0;
            r_pkt_address  <= '0;
            r_pkt_len      <= '0;
            r_pkt_incr     <= '0;
            r_pkt_seq      <= '0;
            r_pkt_ben      <= '0;
            r_pkt_last     <= 1'b0;
        end else begin
            if (w_load) begin
                r_pkt_valid   <= 1'b1;
                r_pkt_write   <= w_src_write;
                r_pkt_address <= w_chunk_addr;
                r_pkt_len     <= w_beats;
                r_pkt_incr    <= w_src_size;
                r_pkt_seq     <= w_seq;
                r_pkt_ben     <= w_ben;
                r_pkt_last    <= (w_rem_after == '0);
                r_addr        <= w_next_addr;
                r_remaining   <= w_rem_after;
            end else if (bus.pkt_ready) begin
                r_pkt_valid   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_prefer_write <= w_grant_read;
                        r_write        <= w_src_write;
                        r_size         <= w_src_size;
                        r_burst        <= w_src_burst;
                        if (w_rem_after != '0) begin
                            r_state <= ST_SPLIT;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (w_split_step && (w_rem_after == '0)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pkt_valid           = r_pkt_valid;
    assign bus.pkt_write           = r_pkt_write;
    assign bus.pkt_address         = r_pkt_address;
    assign bus.pkt_burst_length    = r_pkt_len;
    assign bus.pkt_burst_increment = r_pkt_incr;
    assign bus.pkt_burst_sequence  = r_pkt_seq;
    assign bus.pkt_byte_enables    = r_pkt_ben;
    assign bus.pkt_last            = r_pkt_last;

`ifdef NI_SPLIT_STATS_EN
    logic [15:0] r_stat_reads;
    logic [15:0] r_stat_writes;
    logic [15:0] r_stat_splits;

    // Saturating counters: accepted reads/writes and chunks beyond the first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_splits <= '0;
        end else begin
            if (w_ar_take && (r_stat_reads != 16'hFFFF)) begin
                r_stat_reads <= r_stat_reads + 16'd1;
            end
            if (w_aw_take && (r_stat_writes != 16'hFFFF)) begin
                r_stat_writes <= r_stat_writes + 16'd1;
            end
            if (w_split_step && (r_stat_splits != 16'hFFFF)) begin
                r_stat_splits <= r_stat_splits + 16'd1;
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_splits = r_stat_splits;
`endif

endmodule
`default_nettype wire
